stream_minmax_tracker: RTL and testbench

- Consumes a stream of unsigned 8-bit samples and reports the maximum and minimum of each fixed-length frame, with the sample index of each.
- Sits directly downstream of the team's 8-bit ripple magnitude comparator (EQ/GT outputs), which it instantiates twice: sample vs. running max, and running min vs. sample.
- Adds the sequential layer: valid/ready handshakes, a frame counter, and a frame FSM.

---
 rtl/minmax_pkg.sv | 17 +
 rtl/stream_minmax_tracker_cmp.sv | 23 ++
 rtl/stream_minmax_tracker.sv | 147 ++++++++++++++
 tb/tb_stream_minmax_tracker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared types and constants for the stream min/max tracker.
package minmax_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_e;

  // Width of index/count fields for a frame of 'window' samples.
  function automatic int idx_w(input int window);
    return $clog2(window);
  endfunction

endpackage

// File: rtl/stream_minmax_tracker_cmp.sv
// 8-bit unsigned ripple magnitude comparator: eq_o = (a_i == b_i), gt_o = (a_i > b_i).
module minmax_mag_cmp
  import minmax_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              eq_o,
  output logic              gt_o
);

  // Ripple from the MSB; the first differing bit decides the ordering.
  always_comb begin
    eq_o = 1'b1;
    gt_o = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (eq_o && (a_i[i] != b_i[i])) begin
        gt_o = a_i[i];
        eq_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stream_minmax_tracker.sv
// Per-frame max/min tracker with first-occurrence indices over fixed-length frames.
// Handshakes: a sample moves when in_valid & in_ready at a rising edge; a result moves
// when out_valid & out_ready at a rising edge. in_ready and out_valid are registered and
// never depend combinationally on in_valid or out_ready.
module stream_minmax_tracker
  import minmax_pkg::*;
#(
  parameter  int WINDOW = 16,
  localparam int IDX_W  = idx_w(WINDOW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] min_val,
  output logic [IDX_W-1:0]  max_idx,
  output logic [IDX_W-1:0]  min_idx,
  output logic [IDX_W-1:0]  count,
  output state_e            dbg_state
);

  // Count carries one extra bit so that WINDOW == 2**IDX_W is representable.
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W + 1)'(WINDOW - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   max_q, max_d, min_q, min_d;
  logic [IDX_W-1:0]    max_idx_q, max_idx_d, min_idx_q, min_idx_d;
  logic [IDX_W:0]      count_q, count_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic max_eq, max_gt, min_eq, min_gt;
  logic accept, max_upd, min_upd;

  // Sample vs running max: gt means the sample is a new maximum.
  minmax_mag_cmp u_cmp_max (
    .a_i  (in_data),
    .b_i  (max_q),
    .eq_o (max_eq),
    .gt_o (max_gt)
  );

  // Running min vs sample: gt means the sample is a new minimum.
  minmax_mag_cmp u_cmp_min (
    .a_i  (min_q),
    .b_i  (in_data),
    .eq_o (min_eq),
    .gt_o (min_gt)
  );

  assign accept  = in_valid & in_ready_q;
  // A tie never moves the extreme, which keeps the first-occurrence index.
  assign max_upd = max_gt & ~max_eq;
  assign min_upd = min_gt & ~min_eq;

  // Next-state and datapath update; clear overrides any accept or result handshake.
  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    count_d   = count_q;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            max_d     = in_data;
            min_d     = in_data;
            max_idx_d = '0;
            min_idx_d = '0;
            count_d   = CNT_ONE;
            state_d   = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (max_upd) begin
              max_d     = in_data;
              max_idx_d = count_q[IDX_W-1:0];
            end
            if (min_upd) begin
              min_d     = in_data;
              min_idx_d = count_q[IDX_W-1:0];
            end
            count_d = count_q + CNT_ONE;
            if (count_q == CNT_LAST) state_d = REPORT;
          end
        end
        REPORT: begin
          if (out_valid_q && out_ready) begin
            state_d = IDLE;
            count_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
    in_ready_d  = (state_d != REPORT);
    out_valid_d = (state_d == REPORT);
  end

  // FSM, datapath and registered handshake outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      max_q       <= '0;
      min_q       <= '0;
      max_idx_q   <= '0;
      min_idx_q   <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      min_q       <= min_d;
      max_idx_q   <= max_idx_d;
      min_idx_q   <= min_idx_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign max_val   = max_q;
  assign min_val   = min_q;
  assign max_idx   = max_idx_q;
  assign min_idx   = min_idx_q;
  assign count     = count_q[IDX_W-1:0];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Bench for stream_minmax_tracker with WINDOW = 4: directed frames with literal
// expectations plus randomized traffic checked every cycle against a frame-queue model.
module tb_stream_minmax_tracker;
  import minmax_pkg::*;

  localparam int WINDOW = 4;
  localparam int IDX_W  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       max_val, min_val;
  logic [IDX_W-1:0] max_idx, min_idx, count;
  state_e           dbg_state;

  int checks = 0;
  int errors = 0;

  stream_minmax_tracker #(.WINDOW(WINDOW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .max_val   (max_val),
    .min_val   (min_val),
    .max_idx   (max_idx),
    .min_idx   (min_idx),
    .count     (count),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: the current frame is a queue of accepted samples.
  int   frame[$];
  bit   reporting = 0;
  bit   m_rdy = 0, m_ov = 0;
  int   m_max = 0, m_min = 0, m_maxi = 0, m_mini = 0, m_cnt = 0;

  function automatic void recompute();
    m_max = frame[0]; m_maxi = 0;
    m_min = frame[0]; m_mini = 0;
    for (int i = 1; i < frame.size(); i++) begin
      if (frame[i] > m_max) begin m_max = frame[i]; m_maxi = i; end
      if (frame[i] < m_min) begin m_min = frame[i]; m_mini = i; end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      frame.delete();
      reporting = 0;
      m_rdy = 0; m_ov = 0;
      m_max = 0; m_min = 0; m_maxi = 0; m_mini = 0; m_cnt = 0;
    end else begin
      if (clear) begin
        frame.delete();
        reporting = 0;
      end else if (reporting) begin
        if (out_ready) begin
          reporting = 0;
          frame.delete();
        end
      end else if (in_valid && m_rdy) begin
        frame.push_back(int'(in_data));
        recompute();
        if (frame.size() == WINDOW) reporting = 1;
      end
      m_rdy = !reporting;
      m_ov  = reporting;
      m_cnt = frame.size() % (1 << IDX_W);
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    chk("in_ready",  int'(in_ready),  int'(m_rdy));
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("count",     int'(count),     m_cnt);
    chk("max_val",   int'(max_val),   m_max);
    chk("min_val",   int'(min_val),   m_min);
    chk("max_idx",   int'(max_idx),   m_maxi);
    chk("min_idx",   int'(min_idx),   m_mini);
  end

  // Driver tasks: all start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_result(input string nm, input int mx, input int mxi,
                               input int mn, input int mni);
    int n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 50) begin
        chk({nm, "_timeout"}, 0, 1);
        break;
      end
    end
    chk({nm, "_max"},  int'(max_val), mx);
    chk({nm, "_maxi"}, int'(max_idx), mxi);
    chk({nm, "_min"},  int'(min_val), mn);
    chk({nm, "_mini"}, int'(min_idx), mni);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_ov_drop"}, int'(out_valid), 0);
    chk({nm, "_cnt0"},    int'(count), 0);
    chk({nm, "_rdy"},     int'(in_ready), 1);
  endtask

  initial begin
    // Reset block.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_state", int'(dbg_state), int'(IDLE));
    rst = 1'b0;

    // Basic frame, continuous valid; result visible right after the last accept edge.
    send(8'd10); send(8'd200); send(8'd3); send(8'd57);
    chk("basic_latency", int'(out_valid), 1);
    expect_result("basic", 200, 1, 3, 2);

    // Ties and extremes.
    send(8'd255); send(8'd0); send(8'd255); send(8'd0);
    expect_result("ties", 255, 0, 0, 1);

    // Backpressure.
    send(8'd5); send(8'd5); send(8'd5); send(8'd5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_ov",  int'(out_valid), 1);
      chk("bp_rdy", int'(in_ready), 0);
      chk("bp_max", int'(max_val), 5);
    end
    expect_result("bp", 5, 0, 5, 0);

    // Bubbles.
    send(8'd9); idle(2); send(8'd1);
    chk("bub_count", int'(count), 2);
    send(8'd9); idle(1);
    chk("bub_count_hold", int'(count), 3);
    send(8'd200);
    expect_result("bub", 200, 3, 1, 1);

    // Clear beats a presented sample.
    send(8'd8); send(8'd6);
    in_valid = 1'b1; in_data = 8'd7; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_count", int'(count), 0);
    chk("clr_state", int'(dbg_state), int'(IDLE));
    send(8'd4); send(8'd4); send(8'd4); send(8'd4);
    expect_result("clr", 4, 0, 4, 0);

    // Asynchronous reset mid-frame.
    send(8'd77); send(8'd66);
    rst = 1'b1;
    #1;
    chk("arst_max", int'(max_val), 0);
    chk("arst_min", int'(min_val), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_rdy", int'(in_ready), 0);
    chk("arst_state", int'(dbg_state), int'(IDLE));
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(8'd3); send(8'd1); send(8'd2); send(8'd8);
    expect_result("post_rst", 8, 3, 1, 1);

    // Randomized traffic with the per-cycle model check.
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 3) * 85);
      out_ready = ($urandom_range(0, 2) == 0);
      clear     = ($urandom_range(0, 49) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
